// File: rtl/sprite_pkg.sv
// Shared definitions for the player sprite controller: FSM encodings, USB
// keycodes, playfield X limits and the one-pixel move helper.
package sprite_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ALIVE    = 3'd1;
  localparam state_t ST_EXPLODE  = 3'd2;
  localparam state_t ST_RESPAWN  = 3'd3;
  localparam state_t ST_GAMEOVER = 3'd4;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_FIRE  = 8'h2C;

  localparam int unsigned SCREEN_X_MIN = 0;
  localparam int unsigned SCREEN_X_MAX = 563;

  localparam int TIMER_W = 8;
  localparam int CD_W    = 8;

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic [7:0] key,
                                        input logic [9:0] lo, input logic [9:0] hi);
    logic [9:0] r;
    r = x;
    if (key == KEY_LEFT && x > lo)
      r = x - 10'd1;
    else if (key == KEY_RIGHT && x < hi)
      r = x + 10'd1;
    return r;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; holds at zero and flags it.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count_next,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (count_q != '0)
      count_d = count_q - W'(1);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_next = count_d;
  assign zero       = (count_q == '0);

endmodule

// File: rtl/player_ctrl.sv
// Player ship controller: movement, firing cooldown, lives and the
// explode/respawn/game-over sequence, with all outputs registered.
//
//  state    | meaning
//  IDLE     | after reset, waiting for a game_start edge
//  ALIVE    | player moves and fires; a hit starts the explosion
//  EXPLODE  | explosion sprite shown, input ignored
//  RESPAWN  | blinking and invulnerable at spawn point, can move
//  GAMEOVER | out of lives, waiting for a game_start edge
module player_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned X_MIN          = SCREEN_X_MIN,
  parameter int unsigned X_MAX          = SCREEN_X_MAX,
  parameter int unsigned X_INIT         = 282,
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned EXPLODE_FRAMES = 60,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned FIRE_COOLDOWN  = 15
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       game_start,
  input  logic       player_hit,
  input  logic       missile_busy,
  output logic [9:0] player_x,
  output logic       player_visible,
  output logic       exploding,
  output logic       fire,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [9:0]         XMIN_C       = 10'(X_MIN);
  localparam logic [9:0]         XMAX_C       = 10'(X_MAX);
  localparam logic [9:0]         XINIT_C      = 10'(X_INIT);
  localparam logic [1:0]         LIVES_C      = 2'(LIVES_INIT);
  localparam logic [TIMER_W-1:0] EXPLODE_LOAD = TIMER_W'(EXPLODE_FRAMES - 1);
  localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_FRAMES - 1);
  localparam logic [CD_W-1:0]    CD_LOAD      = CD_W'(FIRE_COOLDOWN);

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [1:0]        lives_q, lives_d;
  logic [CD_W-1:0]   cd_q, cd_d;
  logic              fire_q, fire_d;
  logic              vis_q, vis_d;
  logic              expl_q, expl_d;
  logic              over_q, over_d;
  logic              start_q;
  logic              start_rise;

  logic              tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic [TIMER_W-1:0] tmr_next;
  logic              tmr_zero;

  frame_timer #(.W(TIMER_W)) u_timer (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .count_next (tmr_next),
    .zero       (tmr_zero)
  );

  always_comb begin
    start_rise = game_start & ~start_q;
    state_d    = state_q;
    x_d        = x_q;
    lives_d    = lives_q;
    fire_d     = 1'b0;
    cd_d       = (cd_q != '0) ? cd_q - CD_W'(1) : cd_q;
    tmr_load   = 1'b0;
    tmr_val    = EXPLODE_LOAD;

    case (state_q)
      ST_IDLE, ST_GAMEOVER: begin
        if (start_rise) begin
          state_d = ST_ALIVE;
          x_d     = XINIT_C;
          lives_d = LIVES_C;
          cd_d    = '0;
        end
      end
      ST_ALIVE: begin
        if (player_hit) begin
          state_d  = ST_EXPLODE;
          lives_d  = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          tmr_load = 1'b1;
          tmr_val  = EXPLODE_LOAD;
        end else begin
          x_d = step_x(x_q, keycode, XMIN_C, XMAX_C);
          // The frame in which the cooldown runs out is already eligible,
          // so shots land exactly FIRE_COOLDOWN frames apart.
          if (keycode == KEY_FIRE && !missile_busy && cd_q <= CD_W'(1)) begin
            fire_d = 1'b1;
            cd_d   = CD_LOAD;
          end
        end
      end
      ST_EXPLODE: begin
        if (tmr_zero) begin
          if (lives_q == 2'd0) begin
            state_d = ST_GAMEOVER;
          end else begin
            state_d  = ST_RESPAWN;
            x_d      = XINIT_C;
            tmr_load = 1'b1;
            tmr_val  = RESPAWN_LOAD;
          end
        end
      end
      ST_RESPAWN: begin
        x_d = step_x(x_q, keycode, XMIN_C, XMAX_C);
        if (tmr_zero)
          state_d = ST_ALIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Blink: hidden while bit 3 of the respawn countdown is set.
    vis_d  = (state_d == ST_ALIVE) || (state_d == ST_EXPLODE) ||
             ((state_d == ST_RESPAWN) && ((tmr_next & TIMER_W'(8)) == '0));
    expl_d = (state_d == ST_EXPLODE);
    over_d = (state_d == ST_GAMEOVER);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      x_q     <= XINIT_C;
      lives_q <= 2'd0;
      cd_q    <= '0;
      fire_q  <= 1'b0;
      vis_q   <= 1'b0;
      expl_q  <= 1'b0;
      over_q  <= 1'b0;
      start_q <= game_start;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      lives_q <= lives_d;
      cd_q    <= cd_d;
      fire_q  <= fire_d;
      vis_q   <= vis_d;
      expl_q  <= expl_d;
      over_q  <= over_d;
      start_q <= game_start;
    end
  end

  assign player_x       = x_q;
  assign player_visible = vis_q;
  assign exploding      = expl_q;
  assign fire           = fire_q;
  assign lives          = lives_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: a frame-level game model predicts every registered
// output; a monitor pops predictions from a scoreboard queue and compares.
module tb_player_ctrl;
  import sprite_pkg::*;

  localparam int P_XMIN = 0, P_XMAX = 563, P_XINIT = 282, P_LIVES = 3;
  localparam int P_EXPL = 60, P_RESP = 120, P_COOL = 15;

  logic       frame_clk = 1'b1;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       game_start = 1'b0;
  logic       player_hit = 1'b0;
  logic       missile_busy = 1'b0;
  logic [9:0] player_x;
  logic       player_visible, exploding, fire, game_over;
  logic [1:0] lives;

  player_ctrl dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .keycode        (keycode),
    .game_start     (game_start),
    .player_hit     (player_hit),
    .missile_busy   (missile_busy),
    .player_x       (player_x),
    .player_visible (player_visible),
    .exploding      (exploding),
    .fire           (fire),
    .lives          (lives),
    .game_over      (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int x; int vis; int expl; int fire; int lives; int over;
  } exp_t;

  typedef enum int {M_IDLE, M_ALIVE, M_EXPLODE, M_RESPAWN, M_OVER} mode_e;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    fire_seen = 0;
  bit    started = 0;
  bit    done = 0;

  // Game model: frames remaining in a phase, and frame number of the last shot.
  mode_e m_mode = M_IDLE;
  int    m_x = P_XINIT, m_lives = 0, m_left = 0, m_frame = 0, m_last_shot = -1;
  bit    m_prev = 0;

  function automatic void cmp(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic int moved(int x, logic [7:0] key);
    if (key == 8'h04) return (x > P_XMIN) ? x - 1 : x;
    if (key == 8'h07) return (x < P_XMAX) ? x + 1 : x;
    return x;
  endfunction

  task automatic model(input bit r, input bit gs, input bit hit, input bit busy,
                       input logic [7:0] key, output exp_t e);
    bit rise;
    int shot;
    shot = 0;
    m_frame++;
    if (r) begin
      m_mode = M_IDLE; m_x = P_XINIT; m_lives = 0; m_left = 0;
      m_last_shot = -1; m_prev = gs;
    end else begin
      rise = gs && !m_prev;
      m_prev = gs;
      case (m_mode)
        M_IDLE, M_OVER:
          if (rise) begin
            m_mode = M_ALIVE; m_x = P_XINIT; m_lives = P_LIVES; m_last_shot = -1;
          end
        M_ALIVE:
          if (hit) begin
            m_mode = M_EXPLODE; m_left = P_EXPL;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          end else begin
            m_x = moved(m_x, key);
            if (key == 8'h2C && !busy &&
                (m_last_shot < 0 || m_frame - m_last_shot >= P_COOL)) begin
              shot = 1; m_last_shot = m_frame;
            end
          end
        M_EXPLODE: begin
          m_left--;
          if (m_left == 0) begin
            if (m_lives == 0) m_mode = M_OVER;
            else begin m_mode = M_RESPAWN; m_x = P_XINIT; m_left = P_RESP; end
          end
        end
        M_RESPAWN: begin
          m_x = moved(m_x, key);
          m_left--;
          if (m_left == 0) m_mode = M_ALIVE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    e.x     = m_x;
    e.lives = m_lives;
    e.fire  = shot;
    e.expl  = (m_mode == M_EXPLODE);
    e.over  = (m_mode == M_OVER);
    if (m_mode == M_ALIVE || m_mode == M_EXPLODE) e.vis = 1;
    else if (m_mode == M_RESPAWN) e.vis = (((m_left - 1) / 8) % 2 == 0);
    else e.vis = 0;
  endtask

  task automatic step(input bit r, input bit gs, input bit hit, input bit busy,
                      input logic [7:0] key);
    exp_t e;
    @(negedge frame_clk);
    Reset = r; game_start = gs; player_hit = hit; missile_busy = busy; keycode = key;
    model(r, gs, hit, busy, key, e);
    sb_q.push_back(e);
    started = 1;
  endtask

  initial begin : monitor
    exp_t e;
    wait (started);
    forever begin
      @(posedge frame_clk);
      #1;
      if (sb_q.size() == 0) begin
        if (!done) cmp("scoreboard_entries", 0, 1);
      end else begin
        e = sb_q.pop_front();
        if (fire) fire_seen++;
        cmp("player_x", int'(player_x), e.x);
        cmp("player_visible", int'(player_visible), e.vis);
        cmp("exploding", int'(exploding), e.expl);
        cmp("fire", int'(fire), e.fire);
        cmp("lives", int'(lives), e.lives);
        cmp("game_over", int'(game_over), e.over);
      end
    end
  end

  initial begin : stimulus
    int f0;
    bit gs;
    logic [7:0] k;
    // start level held through reset must not start a game
    repeat (3) step(1, 1, 0, 0, 8'h00);
    repeat (4) step(0, 1, 0, 0, 8'h00);
    cmp("held_start_lives", int'(lives), 0);
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    cmp("start_x", int'(player_x), 282);
    cmp("start_lives", int'(lives), 3);
    cmp("start_visible", int'(player_visible), 1);

    repeat (300) step(0, 0, 0, 0, 8'h07);
    step(0, 0, 0, 0, 8'h00);
    cmp("right_limit", int'(player_x), 563);
    repeat (600) step(0, 0, 0, 0, 8'h04);
    step(0, 0, 0, 0, 8'h00);
    cmp("left_limit", int'(player_x), 0);

    f0 = fire_seen;
    repeat (40) step(0, 0, 0, 0, 8'h2C);
    step(0, 0, 0, 0, 8'h00);
    cmp("fire_count_free", fire_seen - f0, 3);
    repeat (20) step(0, 0, 0, 0, 8'h00);
    f0 = fire_seen;
    repeat (40) step(0, 0, 0, 1, 8'h2C);
    step(0, 0, 0, 0, 8'h00);
    cmp("fire_count_busy", fire_seen - f0, 0);

    // hit together with fire, then explosion and blinking respawn
    repeat (20) step(0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'h2C);
    step(0, 0, 0, 0, 8'h2C);
    cmp("hit_lives", int'(lives), 2);
    cmp("hit_exploding", int'(exploding), 1);
    repeat (190) step(0, 0, 0, 0, 8'h2C);
    step(0, 0, 1, 0, 8'h00);
    repeat (190) step(0, 0, 0, 0, 8'h07);
    step(0, 0, 1, 0, 8'h00);
    repeat (65) step(0, 0, 0, 0, 8'h00);
    cmp("over_lives", int'(lives), 0);
    cmp("over_flag", int'(game_over), 1);
    step(0, 1, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    cmp("restart_lives", int'(lives), 3);

    // reset in the middle of an explosion
    step(0, 0, 1, 0, 8'h00);
    repeat (20) step(0, 0, 0, 0, 8'h00);
    step(1, 0, 1, 0, 8'h2C);
    step(0, 0, 0, 0, 8'h00);
    cmp("rst_exploding", int'(exploding), 0);
    cmp("rst_lives", int'(lives), 0);
    cmp("rst_x", int'(player_x), 282);

    gs = 0;
    repeat (4000) begin
      if ($urandom_range(0, 29) == 0) gs = ~gs;
      case ($urandom_range(0, 5))
        0: k = 8'h04;
        1: k = 8'h07;
        2, 3: k = 8'h2C;
        4: k = 8'h00;
        default: k = 8'($urandom);
      endcase
      step($urandom_range(0, 999) == 0, gs, $urandom_range(0, 99) == 0,
           $urandom_range(0, 2) == 0, k);
    end

    @(posedge frame_clk);
    #2;
    done = 1;
    cmp("scoreboard_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
